aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule generator, one round key per round step.

---
 rtl/aes_key_expand_pkg.sv | 57 +++++
 rtl/aes_key_expand_if.sv | 21 ++
 rtl/aes_key_expand_sbox.sv | 29 ++
 rtl/aes_key_expand.sv | 133 +++++++++++++
 tb/tb_aes_key_expand.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_expand_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
// Optional build macro: AES_KEYEXP_SBOX_PIPE_EN (registered SubWord, 2 cycles/round).
package aes_key_expand_pkg;

  localparam int AES_NR = 10;
  localparam int KEY_W  = 128;

  typedef logic [KEY_W-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SUB    = 2'd2
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for round rnd; zero outside 1..AES_NR so idle decode stays benign.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 1; i <= AES_NR; i++) begin
      if (rnd == 4'(i)) begin
        rc = RCON[i];
      end else begin
        rc = rc;
      end
    end
    return rc;
  endfunction

  // RotWord: cyclic left rotation by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // XOR chain producing round key r from round key r-1 and SubWord(RotWord(w[4r-1])).
  function automatic round_key_t next_round_key(input round_key_t prev,
                                                input logic [31:0] sub_w,
                                                input logic [7:0]  rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = sub_w ^ {rc, 24'h000000};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request/status/schedule bundle between a key-schedule requester and aes_key_expand.
interface aes_key_expand_if;
  import aes_key_expand_pkg::*;

  logic       start;
  round_key_t key;
  logic       busy;
  logic       done;
  logic       keys_valid;
  round_key_t k_sch [0:AES_NR];

  modport master (
    output start, key,
    input  busy, done, keys_valid, k_sch
  );

  modport slave (
    input  start, key,
    output busy, done, keys_valid, k_sch
  );
endinterface

// File: rtl/aes_key_expand_sbox.sv
// Combinational AES forward S-box (FIPS-197 table); also used by the cipher's SubBytes.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Row-major table, entry 0x00 in the top byte; entry x lives at bit offset (255-x)*8 = {~x,3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TABLE[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per round step, schedule held until next start.
// Build option AES_KEYEXP_SBOX_PIPE_EN registers the SubWord result (EXPAND computes, SUB writes),
// doubling the per-round time; the final schedule is identical in both builds.
module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  aes_key_expand_if.slave  kx
);

  state_t      state_q;
  logic [3:0]  rnd_q;
  logic        busy_q;
  logic        done_q;
  logic        kv_q;
  round_key_t  k_sch_q [0:AES_NR];

  round_key_t  prev_s;
  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [31:0] sub_w_s;
  round_key_t  next_key_s;
  logic        last_s;

`ifdef AES_KEYEXP_SBOX_PIPE_EN
  logic [31:0] sub_q;
`endif

  // Select the previous round key k_sch[rnd-1] that feeds the current round.
  always_comb begin
    prev_s = '0;
    case (rnd_q)
      4'd1:    prev_s = k_sch_q[0];
      4'd2:    prev_s = k_sch_q[1];
      4'd3:    prev_s = k_sch_q[2];
      4'd4:    prev_s = k_sch_q[3];
      4'd5:    prev_s = k_sch_q[4];
      4'd6:    prev_s = k_sch_q[5];
      4'd7:    prev_s = k_sch_q[6];
      4'd8:    prev_s = k_sch_q[7];
      4'd9:    prev_s = k_sch_q[8];
      4'd10:   prev_s = k_sch_q[9];
      default: prev_s = '0;
    endcase
  end

  assign rot_s = rot_word(prev_s[31:0]);

  // SubWord: one S-box per byte of the rotated last word.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (rot_s[8*g +: 8]),
      .s_o (sub_s[8*g +: 8])
    );
  end

`ifdef AES_KEYEXP_SBOX_PIPE_EN
  assign sub_w_s = sub_q;
`else
  assign sub_w_s = sub_s;
`endif

  assign next_key_s = next_round_key(prev_s, sub_w_s, rcon_of(rnd_q));
  assign last_s     = (rnd_q == 4'(AES_NR));

  // Control FSM, round counter and schedule register file; outputs are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) begin
        k_sch_q[i] <= '0;
      end
`ifdef AES_KEYEXP_SBOX_PIPE_EN
      sub_q   <= 32'h0000_0000;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start here is accepted even in the cycle done is high.
          if (kx.start) begin
            k_sch_q[0] <= kx.key;
            rnd_q      <= 4'd1;
            busy_q     <= 1'b1;
            kv_q       <= 1'b0;
            state_q    <= EXPAND;
          end else begin
            state_q    <= IDLE;
          end
        end
        EXPAND: begin
`ifdef AES_KEYEXP_SBOX_PIPE_EN
          // Capture SubWord; the round key is committed in SUB from the registered value.
          sub_q   <= sub_s;
          state_q <= SUB;
        end
        SUB: begin
`endif
          // Commit round key rnd; start is ignored while expanding.
          for (int i = 1; i <= AES_NR; i++) begin
            if (rnd_q == 4'(i)) begin
              k_sch_q[i] <= next_key_s;
            end
          end
          if (last_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
          end else begin
            rnd_q   <= rnd_q + 4'd1;
            state_q <= EXPAND;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign kx.busy       = busy_q;
  assign kx.done       = done_q;
  assign kx.keys_valid = kv_q;
  assign kx.k_sch      = k_sch_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 reference model plus directed scenarios.
module tb_aes_key_expand;

`ifdef AES_KEYEXP_SBOX_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int LAT = 10 * STEP + 1;

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] E_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] E_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO   = 128'h0;
  localparam logic [127:0] E_ZERO1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] E_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K_A      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B      = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] K_C      = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K_D      = 128'hdeadbeefcafef00d0badf00d12345678;
  localparam logic [127:0] K_E      = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expand_if kx ();

  aes_key_expand dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kx    (kx.slave)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] sb [0:255];
  bit   model_ready = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 key expansion; returns round key r.
  function automatic logic [127:0] round_key_of(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Reference model: expected busy/done/keys_valid and schedule contents per cycle.
  logic         m_busy;
  logic         m_done;
  logic         m_kv;
  int           m_cnt;
  logic [127:0] m_key;
  logic [127:0] exp_k [0:10];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_kv   <= 1'b0;
      m_cnt  <= 0;
      m_key  <= '0;
      for (int r = 0; r <= 10; r++) exp_k[r] <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if ((m_cnt + 1) % STEP == 0)
          exp_k[(m_cnt + 1) / STEP] <= round_key_of(m_key, (m_cnt + 1) / STEP);
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == 10 * STEP) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_kv   <= 1'b1;
        end
      end else if (kx.start) begin
        m_key    <= kx.key;
        exp_k[0] <= kx.key;
        m_busy   <= 1'b1;
        m_kv     <= 1'b0;
        m_cnt    <= 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ready) begin
      chk("busy", {127'h0, kx.busy}, {127'h0, m_busy});
      chk("done", {127'h0, kx.done}, {127'h0, m_done});
      chk("keys_valid", {127'h0, kx.keys_valid}, {127'h0, m_kv});
      for (int r = 0; r <= 10; r++) chk($sformatf("k_sch[%0d]", r), kx.k_sch[r], exp_k[r]);
    end
  end

  task automatic launch(input logic [127:0] k);
    kx.start = 1'b1;
    kx.key   = k;
    @(posedge clk);
    #1;
    kx.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int lat;
    lat = -1;
    for (int i = 1; i <= LAT + 20; i++) begin
      @(negedge clk);
      if (kx.done) begin
        lat = i;
        break;
      end
    end
    chk(nm, 128'(lat), 128'(LAT));
  endtask

  initial begin
    int n_done;
    kx.start = 1'b0;
    kx.key   = '0;
    build_sbox();

    // Pin the model to published vectors.
    chk("model_fips_k1", round_key_of(K_FIPS, 1), E_FIPS1);
    chk("model_fips_k10", round_key_of(K_FIPS, 10), E_FIPS10);
    chk("model_zero_k10", round_key_of(K_ZERO, 10), E_ZERO10);

    model_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {127'h0, kx.busy}, 128'h0);
    chk("reset_k10", kx.k_sch[10], 128'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: FIPS-197 key
    launch(K_FIPS);
    wait_done("t1_latency");
    chk("t1_k1", kx.k_sch[1], E_FIPS1);
    chk("t1_k10", kx.k_sch[10], E_FIPS10);

    // 2: all-zero key, keys_valid held after done
    repeat (2) @(negedge clk);
    launch(K_ZERO);
    wait_done("t2_latency");
    chk("t2_k1", kx.k_sch[1], E_ZERO1);
    chk("t2_k10", kx.k_sch[10], E_ZERO10);
    repeat (3) @(negedge clk);
    chk("t2_kv_hold", {127'h0, kx.keys_valid}, 128'h1);

    // 3: second start mid-expansion is ignored
    launch(K_A);
    repeat (3) @(negedge clk);
    launch(K_B);
    n_done = 0;
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      @(negedge clk);
      if (kx.done) n_done++;
    end
    chk("t3_single_done", 128'(n_done), 128'd1);
    chk("t3_k10_first_key", kx.k_sch[10], round_key_of(K_A, 10));

    // 4: async reset mid-expansion
    launch(K_C);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy_rst", {127'h0, kx.busy}, 128'h0);
    chk("t4_kv_rst", {127'h0, kx.keys_valid}, 128'h0);
    for (int r = 0; r <= 10; r++) chk($sformatf("t4_k_sch[%0d]_rst", r), kx.k_sch[r], 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(K_D);
    wait_done("t4_latency");
    chk("t4_k10", kx.k_sch[10], round_key_of(K_D, 10));

    // 5: back-to-back start in the done cycle
    @(negedge clk);
    launch(K_FIPS);
    wait_done("t5a_latency");
    launch(K_E);
    chk("t5_kv_drop", {127'h0, kx.keys_valid}, 128'h0);
    wait_done("t5b_latency");
    chk("t5_k1", kx.k_sch[1], round_key_of(K_E, 1));
    chk("t5_k10", kx.k_sch[10], round_key_of(K_E, 10));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
